// File: rtl/retire_trace_buffer_if.sv
// Retire-side and trace-side signal bundle for retire_trace_buffer.
// The buffer uses the slave modport; the retire producer / trace consumer uses master.
interface retire_trace_buffer_if #(
    parameter int XLEN       = 32,
    parameter int IssueWidth = 2
);
    logic [IssueWidth-1:0]           update_i;
    logic [IssueWidth-1:0][XLEN-1:0] pc_i;
    logic [IssueWidth-1:0][XLEN-1:0] instr_i;
    logic [IssueWidth-1:0][XLEN-1:0] reg_data_i;
    logic [IssueWidth-1:0][4:0]      reg_addr_i;
    logic [IssueWidth-1:0][XLEN-1:0] mem_addr_i;
    logic [IssueWidth-1:0][XLEN-1:0] mem_data_i;
    logic [IssueWidth-1:0]           mem_wrt_i;

    logic            trace_valid_o;
    logic            trace_ready_i;
    logic [XLEN-1:0] trace_pc_o;
    logic [XLEN-1:0] trace_instr_o;
    logic [XLEN-1:0] trace_reg_data_o;
    logic [4:0]      trace_reg_addr_o;
    logic [XLEN-1:0] trace_mem_addr_o;
    logic [XLEN-1:0] trace_mem_data_o;
    logic            trace_mem_wrt_o;

    modport slave (
        input  update_i, pc_i, instr_i, reg_data_i, reg_addr_i,
               mem_addr_i, mem_data_i, mem_wrt_i, trace_ready_i,
        output trace_valid_o, trace_pc_o, trace_instr_o, trace_reg_data_o,
               trace_reg_addr_o, trace_mem_addr_o, trace_mem_data_o, trace_mem_wrt_o
    );

    modport master (
        output update_i, pc_i, instr_i, reg_data_i, reg_addr_i,
               mem_addr_i, mem_data_i, mem_wrt_i, trace_ready_i,
        input  trace_valid_o, trace_pc_o, trace_instr_o, trace_reg_data_o,
               trace_reg_addr_o, trace_mem_addr_o, trace_mem_data_o, trace_mem_wrt_o
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Serializes up to two retires per cycle into an in-order first-word-fall-through trace FIFO.
// Optional macro RETIRE_TRACE_CNT_EN adds a 64-bit retire counter output retire_cnt_o.
module retire_trace_buffer #(
    parameter int XLEN       = 32,
    parameter int IssueWidth = 2,
    parameter int Depth      = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    retire_trace_buffer_if.slave   bus,
    output logic [$clog2(Depth):0] count_o,
    output logic                   overflow_o
`ifdef RETIRE_TRACE_CNT_EN
    ,
    output logic [63:0]            retire_cnt_o
`endif
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic [4:0]      reg_addr;
        logic            mem_wrt;
    } entry_t;

    entry_t              mem [Depth];
    entry_t              slot0, slot1, head;
    logic [IssueWidth-1:0] req;
    logic [AW-1:0]       wr_ptr, rd_ptr, wr_ptr_p1;
    logic [CW-1:0]       count_q, free_space, push_cnt;
    logic                overflow_q, pop, acc0, acc1, drop, valid;

    assign req = bus.update_i;

    assign slot0 = '{pc: bus.pc_i[0], instr: bus.instr_i[0], reg_data: bus.reg_data_i[0],
                     mem_addr: bus.mem_addr_i[0], mem_data: bus.mem_data_i[0],
                     reg_addr: bus.reg_addr_i[0], mem_wrt: bus.mem_wrt_i[0]};
    assign slot1 = '{pc: bus.pc_i[1], instr: bus.instr_i[1], reg_data: bus.reg_data_i[1],
                     mem_addr: bus.mem_addr_i[1], mem_data: bus.mem_data_i[1],
                     reg_addr: bus.reg_addr_i[1], mem_wrt: bus.mem_wrt_i[1]};

    // Space freed by a same-cycle pop is usable; slot 1 is dropped before slot 0.
    always_comb begin
        valid      = (count_q != '0);
        pop        = valid && bus.trace_ready_i;
        free_space = CW'(Depth) - count_q + CW'(pop);
        acc0       = req[0] && (free_space >= CW'(1));
        acc1       = req[1] && (free_space >= (req[0] ? CW'(2) : CW'(1)));
        drop       = (req[0] && !acc0) || (req[1] && !acc1);
        push_cnt   = CW'(acc0) + CW'(acc1);
        wr_ptr_p1  = wr_ptr + AW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push_cnt);
            rd_ptr  <= rd_ptr + AW'(pop);
            count_q <= count_q + push_cnt - CW'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers and count alone define what is live.
    always_ff @(posedge clk_i) begin
        if (acc0) begin
            mem[wr_ptr] <= slot0;
        end
        if (acc1) begin
            mem[acc0 ? wr_ptr_p1 : wr_ptr] <= slot1;
        end
    end

    assign head = mem[rd_ptr];

    assign bus.trace_valid_o    = valid;
    assign bus.trace_pc_o       = valid ? head.pc       : '0;
    assign bus.trace_instr_o    = valid ? head.instr    : '0;
    assign bus.trace_reg_addr_o = valid ? head.reg_addr : '0;
    assign bus.trace_reg_data_o = (valid && head.reg_addr != 5'd0) ? head.reg_data : '0;
    assign bus.trace_mem_addr_o = valid ? head.mem_addr : '0;
    assign bus.trace_mem_data_o = valid ? head.mem_data : '0;
    assign bus.trace_mem_wrt_o  = valid ? head.mem_wrt  : 1'b0;

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

`ifdef RETIRE_TRACE_CNT_EN
    // Counts every presented retire, whether or not it found room.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt_o <= '0;
        end else begin
            retire_cnt_o <= retire_cnt_o + 64'(req[0]) + 64'(req[1]);
        end
    end
`endif
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer (Depth=8, XLEN=32).
// Honors RETIRE_TRACE_CNT_EN when the design is built with it.
module tb_retire_trace_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count;
    logic       overflow;
    int         errors = 0;
    int         checks = 0;
`ifdef RETIRE_TRACE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    retire_trace_buffer_if #(.XLEN(32), .IssueWidth(2)) bus ();

    retire_trace_buffer #(.XLEN(32), .IssueWidth(2), .Depth(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .count_o    (count),
        .overflow_o (overflow)
`ifdef RETIRE_TRACE_CNT_EN
        ,
        .retire_cnt_o (retire_cnt)
`endif
    );

    // Per-slot field values are derived from the PC so each entry is distinguishable.
    function automatic logic [31:0] f_instr(input logic [31:0] pc); return pc + 32'h1000; endfunction
    function automatic logic [31:0] f_rdata(input logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
    function automatic logic [31:0] f_maddr(input logic [31:0] pc); return pc + 32'h10; endfunction
    function automatic logic [31:0] f_mdata(input logic [31:0] pc); return ~pc; endfunction
    function automatic logic [4:0]  f_raddr(input logic [31:0] pc); return pc[6:2] | 5'd1; endfunction

    task automatic drive_slot(input int s, input logic [31:0] pc);
        bus.pc_i[s]       = pc;
        bus.instr_i[s]    = f_instr(pc);
        bus.reg_data_i[s] = f_rdata(pc);
        bus.reg_addr_i[s] = f_raddr(pc);
        bus.mem_addr_i[s] = f_maddr(pc);
        bus.mem_data_i[s] = f_mdata(pc);
        bus.mem_wrt_i[s]  = pc[2];
    endtask

    task automatic applyStimulus(input logic [1:0] upd, input logic [31:0] pc0, input logic [31:0] pc1);
        drive_slot(0, pc0);
        drive_slot(1, pc1);
        bus.update_i = upd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_and_tick(input logic [1:0] upd, input logic [31:0] pc0, input logic [31:0] pc1);
        applyStimulus(upd, pc0, pc1);
        tick();
        bus.update_i = 2'b00;
    endtask

    task automatic test_reset();
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (bus.trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.trace_valid_o); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (bus.trace_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", bus.trace_pc_o); end
        checks++; if (bus.trace_reg_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg_data: got %h expected 0", bus.trace_reg_data_o); end
`ifdef RETIRE_TRACE_CNT_EN
        checks++; if (retire_cnt !== 64'd0) begin errors++; $display("[TB] FAIL reset_retire_cnt: got %0d expected 0", retire_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dual_retire();
        bus.trace_ready_i = 1'b1;
        push_and_tick(2'b11, 32'h100, 32'h104);
        checks++; if (bus.trace_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL dual_valid: got %b expected 1", bus.trace_valid_o); end
        checks++; if (bus.trace_pc_o !== 32'h100) begin errors++; $display("[TB] FAIL dual_pc0: got %h expected 100", bus.trace_pc_o); end
        checks++; if (count !== 4'd2) begin errors++; $display("[TB] FAIL dual_count2: got %0d expected 2", count); end
        checks++; if (bus.trace_instr_o !== 32'h1100) begin errors++; $display("[TB] FAIL dual_instr: got %h expected 1100", bus.trace_instr_o); end
        checks++; if (bus.trace_mem_addr_o !== 32'h110) begin errors++; $display("[TB] FAIL dual_mem_addr: got %h expected 110", bus.trace_mem_addr_o); end
        checks++; if (bus.trace_mem_wrt_o !== 1'b0) begin errors++; $display("[TB] FAIL dual_mem_wrt0: got %b expected 0", bus.trace_mem_wrt_o); end
        tick();
        checks++; if (bus.trace_pc_o !== 32'h104) begin errors++; $display("[TB] FAIL dual_pc1: got %h expected 104", bus.trace_pc_o); end
        checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL dual_count1: got %0d expected 1", count); end
        checks++; if (bus.trace_reg_data_o !== 32'hA5A5_0104) begin errors++; $display("[TB] FAIL dual_reg_data: got %h expected a5a50104", bus.trace_reg_data_o); end
        checks++; if (bus.trace_mem_data_o !== 32'hFFFF_FEFB) begin errors++; $display("[TB] FAIL dual_mem_data: got %h expected fffffefb", bus.trace_mem_data_o); end
        checks++; if (bus.trace_mem_wrt_o !== 1'b1) begin errors++; $display("[TB] FAIL dual_mem_wrt1: got %b expected 1", bus.trace_mem_wrt_o); end
        tick();
        checks++; if (bus.trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL dual_empty: got %b expected 0", bus.trace_valid_o); end
    endtask

    task automatic test_slot1_only();
        bus.trace_ready_i = 1'b0;
        push_and_tick(2'b10, 32'hDEAD0, 32'h200);
        checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL slot1_count: got %0d expected 1", count); end
        checks++; if (bus.trace_pc_o !== 32'h200) begin errors++; $display("[TB] FAIL slot1_pc: got %h expected 200", bus.trace_pc_o); end
        tick();
        checks++; if (bus.trace_pc_o !== 32'h200) begin errors++; $display("[TB] FAIL stall_hold_pc: got %h expected 200", bus.trace_pc_o); end
        checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL stall_hold_count: got %0d expected 1", count); end
        bus.trace_ready_i = 1'b1;
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL slot1_drain: got %0d expected 0", count); end
    endtask

    task automatic test_reg_zero();
        bus.trace_ready_i = 1'b0;
        applyStimulus(2'b11, 32'h600, 32'h604);
        bus.reg_addr_i[0] = 5'd0;
        tick();
        bus.update_i = 2'b00;
        checks++; if (bus.trace_reg_addr_o !== 5'd0) begin errors++; $display("[TB] FAIL x0_reg_addr: got %0d expected 0", bus.trace_reg_addr_o); end
        checks++; if (bus.trace_reg_data_o !== 32'h0) begin errors++; $display("[TB] FAIL x0_reg_data: got %h expected 0", bus.trace_reg_data_o); end
        bus.trace_ready_i = 1'b1;
        tick();
        checks++; if (bus.trace_reg_data_o !== 32'hA5A5_0604) begin errors++; $display("[TB] FAIL x1_reg_data: got %h expected a5a50604", bus.trace_reg_data_o); end
        tick();
    endtask

    task automatic test_full_concurrent_pop();
        logic [31:0] base;
        bus.trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            base = 32'h500 + 32'(8 * i);
            push_and_tick(2'b11, base, base + 32'h4);
        end
        checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL fullpop_fill: got %0d expected 8", count); end
        bus.trace_ready_i = 1'b1;
        push_and_tick(2'b01, 32'h520, 32'h0);
        checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL fullpop_count: got %0d expected 8", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            base = 32'h504 + 32'(4 * i);
            checks++; if (bus.trace_pc_o !== base) begin errors++; $display("[TB] FAIL fullpop_order[%0d]: got %h expected %h", i, bus.trace_pc_o, base); end
            tick();
        end
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL fullpop_drained: got %0d expected 0", count); end
    endtask

    task automatic test_wrap();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.trace_ready_i = 1'b0;
        push_and_tick(2'b11, 32'h2E0, 32'h2E4);
        push_and_tick(2'b11, 32'h2E8, 32'h2EC);
        push_and_tick(2'b11, 32'h2F0, 32'h2F4);
        push_and_tick(2'b01, 32'h2F8, 32'h0);
        checks++; if (count !== 4'd7) begin errors++; $display("[TB] FAIL wrap_fill: got %0d expected 7", count); end
        bus.trace_ready_i = 1'b1;
        repeat (7) tick();
        push_and_tick(2'b11, 32'h300, 32'h304);
        checks++; if (bus.trace_pc_o !== 32'h300) begin errors++; $display("[TB] FAIL wrap_first: got %h expected 300", bus.trace_pc_o); end
        checks++; if (count !== 4'd2) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 2", count); end
        tick();
        checks++; if (bus.trace_pc_o !== 32'h304) begin errors++; $display("[TB] FAIL wrap_second: got %h expected 304", bus.trace_pc_o); end
        tick();
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL wrap_drained: got %0d expected 0", count); end
    endtask

    task automatic test_overflow();
        logic [31:0] base;
        bus.trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            base = 32'h400 + 32'(8 * i);
            push_and_tick(2'b11, base, base + 32'h4);
        end
        checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL ovf_fill: got %0d expected 8", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before: got %b expected 0", overflow); end
        push_and_tick(2'b11, 32'h420, 32'h424);
        checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 8", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        bus.trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            base = 32'h400 + 32'(4 * i);
            checks++; if (bus.trace_pc_o !== base) begin errors++; $display("[TB] FAIL ovf_order[%0d]: got %h expected %h", i, bus.trace_pc_o, base); end
            tick();
        end
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL ovf_drained: got %0d expected 0", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_midstream();
        bus.trace_ready_i = 1'b0;
        push_and_tick(2'b11, 32'h500, 32'h504);
        push_and_tick(2'b11, 32'h508, 32'h50C);
        push_and_tick(2'b01, 32'h510, 32'h0);
        checks++; if (count !== 4'd5) begin errors++; $display("[TB] FAIL mid_fill: got %0d expected 5", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.trace_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", bus.trace_valid_o); end
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow: got %b expected 0", overflow); end
        checks++; if (bus.trace_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL mid_pc: got %h expected 0", bus.trace_pc_o); end
        applyStimulus(2'b11, 32'h700, 32'h704);
        tick();
        @(negedge clk);
        rst = 1'b0;
        bus.update_i = 2'b00;
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL mid_discard: got %0d expected 0", count); end
        push_and_tick(2'b01, 32'h800, 32'h0);
        checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL mid_after_count: got %0d expected 1", count); end
        checks++; if (bus.trace_pc_o !== 32'h800) begin errors++; $display("[TB] FAIL mid_after_pc: got %h expected 800", bus.trace_pc_o); end
`ifdef RETIRE_TRACE_CNT_EN
        checks++; if (retire_cnt !== 64'd1) begin errors++; $display("[TB] FAIL mid_retire_cnt: got %0d expected 1", retire_cnt); end
`endif
        bus.trace_ready_i = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.trace_ready_i = 1'b0;
        applyStimulus(2'b00, 32'h0, 32'h0);
        #2;
        test_reset();
        test_dual_retire();
        test_slot1_only();
        test_reg_zero();
        test_full_concurrent_pop();
        test_wrap();
        test_overflow();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
